// File: rtl/servo_motion_sequencer.sv
// rtl/servo_motion_sequencer.sv - turntable/track servo motion sequencer; SERVO_SEQ_HOLD_EN keeps servos enabled in IDLE
module servo_motion_sequencer #(
    parameter int TICK_DIV  = 24000,
    parameter int RAMP_STEP = 1,
    parameter int PUSH_T    = 500,
    parameter int DWELL_T   = 200,
    parameter int PULL_T    = 500,
    parameter int SETTLE_T  = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] instr,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic       abort,
    output logic [7:0] turntable_position,
    output logic       turntable_enable,
    output logic [7:0] track_position,
    output logic       track_enable,
    output logic       busy,
    output logic       done,
    output logic       aborted
);
    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]    STEP8      = 8'(RAMP_STEP);
    localparam logic [8:0]    STEP9      = 9'(RAMP_STEP);
`ifdef SERVO_SEQ_HOLD_EN
    localparam logic          IDLE_EN    = 1'b1;
`else
    localparam logic          IDLE_EN    = 1'b0;
`endif

    typedef enum logic [2:0] {
        HOME      = 3'd0,
        IDLE      = 3'd1,
        TT_RAMP   = 3'd2,
        TT_SETTLE = 3'd3,
        PUSH      = 3'd4,
        DWELL     = 3'd5,
        PULL      = 3'd6
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] prescaler;
    logic [15:0]   ticks;
    logic [7:0]    target;
    logic          retracted, tt_pending, auto_cycle;
    logic          tick, accept, abort_take, ramp_hit;
    logic          push_end, dwell_end, pull_end, settle_end;
    logic          set_retracted, clr_retracted, set_pending, clr_pending, latch_auto;
    logic [7:0]    ramp_pos;
    logic [8:0]    gap;

    assign tick       = (prescaler == PRESC_LAST);
    assign push_end   = tick && (ticks == 16'(PUSH_T - 1));
    assign dwell_end  = tick && (ticks == 16'(DWELL_T - 1));
    assign pull_end   = tick && (ticks == 16'(PULL_T - 1));
    assign settle_end = tick && (ticks == 16'(SETTLE_T - 1));
    assign accept     = (state == IDLE) && instr_valid && instr_ready && !abort;
    assign ramp_hit   = tick && (ramp_pos == target);

    // Step toward target, landing exactly on it rather than overshooting or wrapping.
    always_comb begin
        gap      = 9'd0;
        ramp_pos = turntable_position;
        if (target > turntable_position) begin
            gap      = {1'b0, target} - {1'b0, turntable_position};
            ramp_pos = (gap <= STEP9) ? target : turntable_position + STEP8;
        end else if (target < turntable_position) begin
            gap      = {1'b0, turntable_position} - {1'b0, target};
            ramp_pos = (gap <= STEP9) ? target : turntable_position - STEP8;
        end
    end

    always_comb begin
        state_next    = state;
        abort_take    = 1'b0;
        set_retracted = 1'b0;
        clr_retracted = 1'b0;
        set_pending   = 1'b0;
        clr_pending   = 1'b0;
        latch_auto    = 1'b0;
        if (abort && (state != HOME) && (state != PULL)) begin
            abort_take = 1'b1;
            state_next = PULL;
        end else begin
            case (state)
                HOME: begin
                    if (pull_end) begin
                        set_retracted = 1'b1;
                        state_next    = IDLE;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        case (instr[9:8])
                            2'b01: begin
                                if (!retracted) begin
                                    set_pending = 1'b1;
                                    state_next  = PULL;
                                end else if (instr[7:0] == turntable_position) begin
                                    state_next = TT_SETTLE;
                                end else begin
                                    state_next = TT_RAMP;
                                end
                            end
                            2'b10: begin
                                clr_retracted = 1'b1;
                                latch_auto    = 1'b1;
                                state_next    = PUSH;
                            end
                            2'b11:   state_next = PULL;
                            default: state_next = IDLE;
                        endcase
                    end
                end
                TT_RAMP:   if (ramp_hit) state_next = TT_SETTLE;
                TT_SETTLE: if (settle_end) state_next = IDLE;
                PUSH:      if (push_end) state_next = auto_cycle ? DWELL : IDLE;
                DWELL:     if (dwell_end) state_next = PULL;
                PULL: begin
                    if (pull_end) begin
                        set_retracted = 1'b1;
                        if (tt_pending) begin
                            clr_pending = 1'b1;
                            state_next  = (target == turntable_position) ? TT_SETTLE : TT_RAMP;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = HOME;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HOME;
            prescaler <= '0;
            ticks     <= 16'd0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                prescaler <= '0;
                ticks     <= 16'd0;
            end else if (tick) begin
                prescaler <= '0;
                ticks     <= ticks + 16'd1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target             <= 8'h00;
            retracted          <= 1'b0;
            tt_pending         <= 1'b0;
            auto_cycle         <= 1'b0;
            aborted            <= 1'b0;
            turntable_position <= 8'h80;
            instr_ready        <= 1'b0;
            busy               <= 1'b1;
            done               <= 1'b0;
        end else begin
            if (accept && (instr[9:8] == 2'b01)) target <= instr[7:0];
            if (set_retracted) retracted <= 1'b1;
            else if (clr_retracted) retracted <= 1'b0;
            if (abort_take || clr_pending) tt_pending <= 1'b0;
            else if (set_pending) tt_pending <= 1'b1;
            if (abort_take) auto_cycle <= 1'b0;
            else if (latch_auto) auto_cycle <= instr[7];
            if (abort_take) aborted <= 1'b1;
            else if (accept) aborted <= 1'b0;
            if ((state == TT_RAMP) && tick && !abort_take) turntable_position <= ramp_pos;
            // Handshake/status track the state itself so a new instr is never seen as accepted late.
            instr_ready <= (state_next == IDLE);
            busy        <= (state_next != IDLE);
            done        <= (state_next == IDLE) && ((state != IDLE) || accept);
        end
    end

    // Servo drive follows the state one clock later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            track_position   <= 8'h00;
            track_enable     <= 1'b0;
            turntable_enable <= 1'b0;
        end else begin
            case (state)
                HOME, PULL: begin
                    track_position   <= 8'h00;
                    track_enable     <= 1'b1;
                    turntable_enable <= 1'b0;
                end
                PUSH, DWELL: begin
                    track_position   <= 8'hFF;
                    track_enable     <= 1'b1;
                    turntable_enable <= 1'b0;
                end
                TT_RAMP, TT_SETTLE: begin
                    track_enable     <= 1'b0;
                    turntable_enable <= 1'b1;
                end
                IDLE: begin
                    track_enable     <= IDLE_EN;
                    turntable_enable <= IDLE_EN;
                end
                default: begin
                    track_enable     <= 1'b0;
                    turntable_enable <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_servo_motion_sequencer.sv
// tb/tb_servo_motion_sequencer.sv - scoreboard bench for servo_motion_sequencer
module tb_servo_motion_sequencer;
    localparam int K_TR   = 0;
    localparam int K_TT   = 1;
    localparam int K_DONE = 2;
`ifdef SERVO_SEQ_HOLD_EN
    localparam int EXP_IDLE_EN = 1;
`else
    localparam int EXP_IDLE_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] instr = 10'd0;
    logic       instr_valid = 1'b0;
    logic       abort = 1'b0;
    logic       instr_ready, turntable_enable, track_enable, busy, done, aborted;
    logic [7:0] turntable_position, track_position;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc = 0;

    typedef struct {
        int kind;
        int v1;
        int v2;
        int ab;
        int at;
    } ev_t;
    ev_t exp_q[$];

    servo_motion_sequencer #(
        .TICK_DIV(4), .RAMP_STEP(16), .PUSH_T(3), .DWELL_T(2), .PULL_T(3), .SETTLE_T(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .abort(abort),
        .turntable_position(turntable_position),
        .turntable_enable(turntable_enable),
        .track_position(track_position),
        .track_enable(track_enable),
        .busy(busy),
        .done(done),
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int v1, input int v2, input int ab, input int off);
        ev_t e;
        e.kind = kind;
        e.v1   = v1;
        e.v2   = v2;
        e.ab   = ab;
        e.at   = acc + off;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input int v1, input int v2, input int ab);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: kind %0d value %0h at cycle %0d, expected no event", kind, v1, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.at);
            check("event_value", v1, e.v1);
            if (kind == K_DONE) begin
                check("done_track", v2, e.v2);
                check("done_aborted", ab, e.ab);
            end
        end
    endtask

    // Monitor: pops an expectation whenever an output changes or done pulses.
    initial begin
        logic [7:0] prev_tt;
        logic [7:0] prev_tr;
        logic       idle_chk;
        prev_tt  = 8'h80;
        prev_tr  = 8'h00;
        idle_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_tt  = 8'h80;
                prev_tr  = 8'h00;
                idle_chk = 1'b0;
            end else begin
                if (idle_chk) begin
                    check("idle_tt_enable", int'(turntable_enable), EXP_IDLE_EN);
                    check("idle_track_enable", int'(track_enable), EXP_IDLE_EN);
                end
                idle_chk = done;
                if (track_position != prev_tr) observe(K_TR, int'(track_position), 0, 0);
                if (turntable_position != prev_tt) observe(K_TT, int'(turntable_position), 0, 0);
                if (done) begin
                    observe(K_DONE, int'(turntable_position), int'(track_position), int'(aborted));
                    check("done_busy", int'(busy), 0);
                    check("done_ready", int'(instr_ready), 1);
                end
                prev_tt = turntable_position;
                prev_tr = track_position;
            end
        end
    end

    task automatic send(input logic [9:0] word);
        int n;
        n = 0;
        while (!instr_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", int'(instr_ready), 1);
        instr       = word;
        instr_valid = 1'b1;
        acc         = cyc + 1;
    endtask

    task automatic release_valid();
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", int'(done), 1);
    endtask

    task automatic check_reset_values();
        check("rst_tt_pos", int'(turntable_position), 'h80);
        check("rst_track_pos", int'(track_position), 'h00);
        check("rst_tt_en", int'(turntable_enable), 0);
        check("rst_track_en", int'(track_enable), 0);
        check("rst_ready", int'(instr_ready), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_done", int'(done), 0);
        check("rst_aborted", int'(aborted), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset_values();
        acc = 0;
        expect_ev(K_DONE, 'h80, 'h00, 0, 12);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("home_track_enable", int'(track_enable), 1);
        wait_done();

        // no-op
        send({2'b00, 8'h00});
        expect_ev(K_DONE, 'h80, 'h00, 0, 0);
        release_valid();
        wait_done();

        // ramp 80 -> A0
        send({2'b01, 8'hA0});
        expect_ev(K_TT, 'h90, 0, 0, 4);
        expect_ev(K_TT, 'hA0, 0, 0, 8);
        expect_ev(K_DONE, 'hA0, 'h00, 0, 16);
        release_valid();
        wait_done();

        // auto push / dwell / pull
        send({2'b10, 8'h80});
        expect_ev(K_TR, 'hFF, 0, 0, 1);
        expect_ev(K_TR, 'h00, 0, 0, 21);
        expect_ev(K_DONE, 'hA0, 'h00, 0, 32);
        release_valid();
        wait_done();

        // push without auto: track stays extended
        send({2'b10, 8'h00});
        expect_ev(K_TR, 'hFF, 0, 0, 1);
        expect_ev(K_DONE, 'hA0, 'hFF, 0, 12);
        release_valid();
        wait_done();

        // turntable move while extended: interlock pull first, then ramp A0 -> 00
        send({2'b01, 8'h00});
        expect_ev(K_TR, 'h00, 0, 0, 1);
        for (int k = 1; k <= 10; k++) expect_ev(K_TT, 'hA0 - 16 * k, 0, 0, 12 + 4 * k);
        expect_ev(K_DONE, 'h00, 'h00, 0, 60);
        release_valid();
        wait_done();

        // abort in mid push, held into PULL
        send({2'b10, 8'h00});
        expect_ev(K_TR, 'hFF, 0, 0, 1);
        expect_ev(K_TR, 'h00, 0, 0, 7);
        expect_ev(K_DONE, 'h00, 'h00, 1, 18);
        release_valid();
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        check("abort_flag_set", int'(aborted), 1);
        check("abort_busy", int'(busy), 1);
        repeat (4) @(negedge clk);
        abort = 1'b0;
        wait_done();

        // next accept clears aborted
        send({2'b00, 8'h00});
        expect_ev(K_DONE, 'h00, 'h00, 0, 0);
        release_valid();
        wait_done();

        // ramp 00 -> F8 with final clamp
        send({2'b01, 8'hF8});
        for (int k = 1; k <= 16; k++) expect_ev(K_TT, (16 * k > 'hF8) ? 'hF8 : 16 * k, 0, 0, 4 * k);
        expect_ev(K_DONE, 'hF8, 'h00, 0, 72);
        release_valid();
        wait_done();

        // F8 -> FF must clamp, not wrap
        send({2'b01, 8'hFF});
        expect_ev(K_TT, 'hFF, 0, 0, 4);
        expect_ev(K_DONE, 'hFF, 'h00, 0, 12);
        release_valid();
        wait_done();

        // target equals position: settle only
        send({2'b01, 8'hFF});
        expect_ev(K_DONE, 'hFF, 'h00, 0, 8);
        release_valid();
        wait_done();

        // explicit pull
        send({2'b11, 8'h00});
        expect_ev(K_DONE, 'hFF, 'h00, 0, 12);
        release_valid();
        wait_done();

        // async reset mid push, then re-home
        send({2'b10, 8'h00});
        expect_ev(K_TR, 'hFF, 0, 0, 1);
        release_valid();
        repeat (5) @(negedge clk);
        check("queue_empty_before_reset", exp_q.size(), 0);
        #1 reset_n = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        @(negedge clk);
        acc = 0;
        expect_ev(K_DONE, 'h80, 'h00, 0, 12);
        #1 reset_n = 1'b1;
        wait_done();

        // after re-home the turntable is at 80 and retracted
        send({2'b01, 8'h80});
        expect_ev(K_DONE, 'h80, 'h00, 0, 8);
        release_valid();
        wait_done();

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
